// File: rtl/spi_ram_arbiter.sv
// SPI command decoder and round-robin arbiter sharing one single-port RAM with a local host port.
// Optional SPI_RAM_ARB_AUTOINC_EN: post-increment the SPI write/read address on every accepted RAM command.
module spi_ram_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]            host_wdata,
  output logic                  host_gnt,
  output logic [7:0]            host_rdata,
  output logic                  host_rvalid,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  output logic                  spi_ovf,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, SPI_ACC, HOST_ACC, RD_WAIT} state_t;

  state_t state, state_nxt;

  logic                  rx_valid_q;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

  logic                  spi_pend;
  logic                  spi_we;
  logic [ADDR_WIDTH-1:0] spi_addr;
  logic [7:0]            spi_wdata;

  logic                  hq_we;
  logic [ADDR_WIDTH-1:0] hq_addr;
  logic [7:0]            hq_wdata;

  logic                  last_gnt_host;
  logic                  rd_owner_host;

  logic                  accept;
  logic [1:0]            opcode;
  logic                  spi_ram_cmd;
  logic                  slot_free;

  assign accept      = rx_valid & ~rx_valid_q;
  assign opcode      = rx_data[9:8];
  assign spi_ram_cmd = accept & opcode[0];
  assign slot_free   = ~spi_pend | (state == SPI_ACC);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A RAM command accepted in the IDLE cycle counts as pending, so its ram_en lands one cycle after accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if ((spi_pend | spi_ram_cmd) && (!host_req || last_gnt_host))
          state_nxt = SPI_ACC;
        else if (host_req)
          state_nxt = HOST_ACC;
      end
      SPI_ACC:  state_nxt = spi_we ? IDLE : RD_WAIT;
      HOST_ACC: state_nxt = hq_we ? IDLE : RD_WAIT;
      RD_WAIT:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    host_gnt  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      SPI_ACC: begin
        ram_en    = 1'b1;
        ram_we    = spi_we;
        ram_addr  = spi_addr;
        ram_wdata = spi_wdata;
      end
      HOST_ACC: begin
        ram_en    = 1'b1;
        ram_we    = hq_we;
        ram_addr  = hq_addr;
        ram_wdata = hq_wdata;
        host_gnt  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
    end else begin
      rx_valid_q <= rx_valid;
      if (accept) begin
        case (opcode)
          2'b00: wr_addr <= rx_data[ADDR_WIDTH-1:0];
          2'b10: rd_addr <= rx_data[ADDR_WIDTH-1:0];
`ifdef SPI_RAM_ARB_AUTOINC_EN
          2'b01: wr_addr <= wr_addr + ADDR_WIDTH'(1);
          2'b11: rd_addr <= rd_addr + ADDR_WIDTH'(1);
`endif
          default: ;
        endcase
      end
    end
  end

  // The slot keeps the address captured at accept; a granted slot may be refilled in its SPI_ACC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_pend  <= 1'b0;
      spi_we    <= 1'b0;
      spi_addr  <= '0;
      spi_wdata <= '0;
      spi_ovf   <= 1'b0;
    end else begin
      if (state == SPI_ACC)
        spi_pend <= 1'b0;
      if (spi_ram_cmd) begin
        if (slot_free) begin
          spi_pend  <= 1'b1;
          spi_we    <= ~opcode[1];
          spi_addr  <= opcode[1] ? rd_addr : wr_addr;
          spi_wdata <= rx_data[7:0];
        end else begin
          spi_ovf <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hq_we         <= 1'b0;
      hq_addr       <= '0;
      hq_wdata      <= '0;
      last_gnt_host <= 1'b1;
      rd_owner_host <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == HOST_ACC) begin
        hq_we    <= host_we;
        hq_addr  <= host_addr;
        hq_wdata <= host_wdata;
      end
      if (state == SPI_ACC) begin
        last_gnt_host <= 1'b0;
        rd_owner_host <= 1'b0;
      end else if (state == HOST_ACC) begin
        last_gnt_host <= 1'b1;
        rd_owner_host <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      tx_valid    <= 1'b0;
      host_rvalid <= 1'b0;
      if (state == RD_WAIT) begin
        if (rd_owner_host) begin
          host_rdata  <= ram_rdata;
          host_rvalid <= 1'b1;
        end else begin
          tx_data  <= ram_rdata;
          tx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter: expected RAM accesses and read bytes are queued by the stimulus
// and checked by an independent monitor against a behavioural RAM.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       spi_ovf, busy;
  logic       mem_init = 1'b1;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .spi_ovf(spi_ovf), .busy(busy)
  );

  // Behavioural RAM, initial contents mem[a] = a ^ 0x5A
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= i[7:0] ^ 8'h5A;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct packed {
    logic       host;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  acc_t       acc_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] hr_q[$];
  int checks = 0;
  int errors = 0;

`ifdef SPI_RAM_ARB_AUTOINC_EN
  localparam logic [7:0] WRAP_ADDR = 8'h00;
`else
  localparam logic [7:0] WRAP_ADDR = 8'hFF;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every RAM strobe and every read-data pulse must match the head of its queue
  always @(negedge clk) begin
    acc_t e;
    logic [7:0] d;
    if (ram_en) begin
      checks++;
      if (acc_q.size() == 0) begin
        errors++;
        $display("FAIL ram_access unexpected host=%0b we=%0b addr=%h wdata=%h", host_gnt, ram_we, ram_addr, ram_wdata);
      end else begin
        e = acc_q.pop_front();
        if (host_gnt !== e.host || ram_we !== e.we || ram_addr !== e.addr || (e.we && ram_wdata !== e.wdata)) begin
          errors++;
          $display("FAIL ram_access actual host=%0b we=%0b addr=%h wdata=%h required host=%0b we=%0b addr=%h wdata=%h",
                   host_gnt, ram_we, ram_addr, ram_wdata, e.host, e.we, e.addr, e.wdata);
        end
      end
    end
    if (tx_valid) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_data unexpected actual=%h", tx_data);
      end else begin
        d = tx_q.pop_front();
        if (tx_data !== d) begin
          errors++;
          $display("FAIL tx_data actual=%h required=%h", tx_data, d);
        end
      end
    end
    if (host_rvalid) begin
      checks++;
      if (hr_q.size() == 0) begin
        errors++;
        $display("FAIL host_rdata unexpected actual=%h", host_rdata);
      end else begin
        d = hr_q.pop_front();
        if (host_rdata !== d) begin
          errors++;
          $display("FAIL host_rdata actual=%h required=%h", host_rdata, d);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic spi_cmd(input logic [9:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
  endtask

  task automatic host_set(input logic we, input logic [7:0] a, input logic [7:0] d);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
  endtask

  // Waits (bounded) for host_gnt, clearing any one-cycle SPI pulse issued alongside the request
  task automatic host_wait();
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick(1);
      rx_valid = 1'b0;
      if (host_gnt) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL host_gnt_timeout actual=0 required=1");
    end
    tick(1);
    host_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    rst = 1'b0;
    mem_init = 1'b0;
    check("reset_outputs",
          {8'h0, tx_data, host_rdata, ram_addr},
          32'h0);
    check("reset_strobes",
          {24'h0, tx_valid, host_gnt, host_rvalid, ram_en, ram_we, spi_ovf, busy, |ram_wdata},
          32'h0);

    // Write 0xA5 at 0x12, then read it back with latency check
    acc_q.push_back(acc_t'{1'b0, 1'b1, 8'h12, 8'hA5});
    acc_q.push_back(acc_t'{1'b0, 1'b0, 8'h12, 8'h00});
    tx_q.push_back(8'hA5);
    spi_cmd(10'h012);
    spi_cmd(10'h1A5);
    spi_cmd(10'h212);
    rx_data = 10'h300;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    check("read_ram_en_n1", {31'h0, ram_en}, 32'h1);
    tick(1);
    check("tx_valid_n2", {31'h0, tx_valid}, 32'h0);
    tick(1);
    check("tx_valid_n3", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hA5});
    tick(2);

    // Level-held rx_valid accepts only once
    spi_cmd(10'h020);
    acc_q.push_back(acc_t'{1'b0, 1'b1, 8'h20, 8'hA5});
    rx_data = 10'h1A5;
    rx_valid = 1'b1;
    tick(20);
    rx_valid = 1'b0;
    tick(4);

    // Simultaneous after reset: SPI first, then host; second round same order
    do_reset();
    spi_cmd(10'h230);
    acc_q.push_back(acc_t'{1'b0, 1'b0, 8'h30, 8'h00});
    acc_q.push_back(acc_t'{1'b1, 1'b0, 8'h12, 8'h00});
    tx_q.push_back(8'h6A);
    hr_q.push_back(8'hA5);
    host_set(1'b0, 8'h12, 8'h00);
    rx_data = 10'h300;
    rx_valid = 1'b1;
    host_wait();
    tick(4);
    spi_cmd(10'h231);
    acc_q.push_back(acc_t'{1'b0, 1'b0, 8'h31, 8'h00});
    acc_q.push_back(acc_t'{1'b1, 1'b0, 8'h13, 8'h00});
    tx_q.push_back(8'h6B);
    hr_q.push_back(8'h49);
    host_set(1'b0, 8'h13, 8'h00);
    rx_data = 10'h300;
    rx_valid = 1'b1;
    host_wait();
    tick(4);

    // SPI read of 0x40 beats the host write to 0x40, host read-back sees 0x3C
    spi_cmd(10'h240);
    acc_q.push_back(acc_t'{1'b0, 1'b0, 8'h40, 8'h00});
    acc_q.push_back(acc_t'{1'b1, 1'b1, 8'h40, 8'h3C});
    tx_q.push_back(8'h1A);
    host_set(1'b1, 8'h40, 8'h3C);
    rx_data = 10'h300;
    rx_valid = 1'b1;
    host_wait();
    tick(2);
    acc_q.push_back(acc_t'{1'b1, 1'b0, 8'h40, 8'h00});
    hr_q.push_back(8'h3C);
    host_set(1'b0, 8'h40, 8'h00);
    host_wait();
    tick(4);

    // last_gnt = SPI: host wins the tie
    spi_cmd(10'h050);
    acc_q.push_back(acc_t'{1'b0, 1'b1, 8'h50, 8'h77});
    spi_cmd(10'h177);
    spi_cmd(10'h250);
    acc_q.push_back(acc_t'{1'b1, 1'b0, 8'h50, 8'h00});
    acc_q.push_back(acc_t'{1'b0, 1'b0, 8'h50, 8'h00});
    hr_q.push_back(8'h77);
    tx_q.push_back(8'h77);
    host_set(1'b0, 8'h50, 8'h00);
    rx_data = 10'h300;
    rx_valid = 1'b1;
    host_wait();
    tick(6);

    // Overflow: second 01 arrives while the host read holds the RAM
    spi_cmd(10'h060);
    acc_q.push_back(acc_t'{1'b1, 1'b0, 8'h12, 8'h00});
    acc_q.push_back(acc_t'{1'b0, 1'b1, 8'h60, 8'hB1});
    hr_q.push_back(8'hA5);
    host_set(1'b0, 8'h12, 8'h00);
    rx_data = 10'h1B1;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    check("ovf_host_gnt", {31'h0, host_gnt}, 32'h1);
    tick(1);
    host_req = 1'b0;
    rx_data = 10'h1C2;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    check("spi_ovf_set", {31'h0, spi_ovf}, 32'h1);
    tick(8);
    check("spi_ovf_sticky", {31'h0, spi_ovf}, 32'h1);
    do_reset();
    check("spi_ovf_cleared", {31'h0, spi_ovf}, 32'h0);

    // Reset during RD_WAIT suppresses tx_valid
    acc_q.push_back(acc_t'{1'b0, 1'b0, 8'h00, 8'h00});
    rx_data = 10'h300;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("midreset_quiet", {30'h0, tx_valid, busy}, 32'h0);

    // Address wrap: autoinc goes 0xFF -> 0x00
    spi_cmd(10'h0FF);
    acc_q.push_back(acc_t'{1'b0, 1'b1, 8'hFF, 8'h11});
    acc_q.push_back(acc_t'{1'b0, 1'b1, WRAP_ADDR, 8'h22});
    spi_cmd(10'h111);
    spi_cmd(10'h122);
    tick(5);

    check("acc_q_drained", acc_q.size(), 32'h0);
    check("tx_q_drained", tx_q.size(), 32'h0);
    check("hr_q_drained", hr_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
